// File: rtl/wb_arb8_32.sv
// wb_arb8_32: 8-lane arbiter feeding a shared 32-bit result register.
// Each cycle one requesting lane is granted. Its word is steered through an
// 8:1 select into a single-entry output register, which is drained by a
// valid/ready handshake.
// Build option: define WB_ARB_FIXED_PRIO_EN to make the lowest-numbered
// requesting lane always win. The default build is round-robin starting
// after the last granted lane.
module wb_arb8_32 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            req,
  input  logic [8*DATA_W-1:0]   din,
  output logic [7:0]            gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel
);

  localparam int unsigned N_LANES = 8;
  localparam int unsigned SEL_W   = 3;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  win;
  logic [DATA_W-1:0] win_data;
  logic              any_req;
  logic              cap;
  logic              capture;

  // Winner selection; scanning from the far end so the nearest candidate is assigned last.
  always_comb begin
    win     = '0;
    any_req = |req;
`ifdef WB_ARB_FIXED_PRIO_EN
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (req[k]) win = SEL_W'(k);
    end
`else
    for (int k = N_LANES; k >= 1; k--) begin
      if (req[SEL_W'(ptr + SEL_W'(k))]) win = SEL_W'(ptr + SEL_W'(k));
    end
`endif
  end

  // 8:1 lane data select.
  always_comb begin
    win_data = din[32'(win) * DATA_W +: DATA_W];
  end

  // Next state, capture enable and the combinational grant.
  always_comb begin
    state_next = state;
    cap        = (state == EMPTY) || (out_valid && out_ready);
    capture    = cap && any_req;
    gnt        = '0;
    case (state)
      EMPTY: begin
        if (any_req) state_next = FULL;
      end
      FULL: begin
        if (out_ready) state_next = any_req ? FULL : EMPTY;
      end
      default: state_next = EMPTY;
    endcase
    if (rst_n && capture) gnt = 8'(8'd1 << win);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= 3'd7;
    end else begin
      out_valid <= (state_next == FULL);
      if (capture) begin
        out_data <= win_data;
        out_sel  <= win;
        ptr      <= win;
      end
    end
  end

endmodule
